mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (fetch side "i", data side "d") in front
// of a single shared memory port. One transaction is granted at a time; the
// granted requester's signals are steered straight through to pmem_*, and the
// memory's completion is steered back as that requester's resp pulse.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie in IDLE, grant the side opposite last_grant
//   undefined -> on a tie in IDLE, the data side always wins
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  // fetch side
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  // data side
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  // shared memory
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_addr,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_wmask,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  // status
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  // last_grant encoding: which side most recently entered a grant state
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t state, state_next;
  logic   last_grant;
  logic   d_req;

  assign d_req = d_read | d_write;

  // State and last_grant registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_D;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next != IDLE)
        last_grant <= (state_next == GRANT_D) ? LAST_D : LAST_I;
    end
  end

  // Next-state: arbitrate in IDLE, hold a grant until the memory completes.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_read && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_next = (last_grant == LAST_D) ? GRANT_I : GRANT_D;
`else
          state_next = GRANT_D;
`endif
        end else if (d_req) begin
          state_next = GRANT_D;
        end else if (i_read) begin
          state_next = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: pure state decode plus combinational steering of the granted side.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    pmem_wmask = '0;
    i_rdata    = '0;
    i_resp     = 1'b0;
    d_rdata    = '0;
    d_resp     = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      GRANT_I: begin
        pmem_read = i_read;
        pmem_addr = i_addr;
        i_resp    = pmem_resp;
        i_rdata   = pmem_rdata;
      end
      GRANT_D: begin
        // read and write together is a write
        pmem_read  = d_read & ~d_write;
        pmem_write = d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        pmem_wmask = d_wmask;
        d_resp     = pmem_resp;
        d_rdata    = pmem_rdata;
      end
      default: ;
    endcase
  end

endmodule
